vga_text_fetch: RTL

- Display-side stage directly downstream of the ARM processor core.
- On a rising edge of the "show letter" strobe, reads a fixed window of processor data memory through the memory's VGA read port and unpacks the bytes into a character line buffer.
- The buffer is read by the VGA pixel generator.
- Also drives one seven-segment digit showing the low nibble of character 0.

---
 rtl/vga_text_pkg.sv | 34 +++
 rtl/vga_text_fetch_7seg.sv | 14 +
 rtl/vga_text_fetch.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/vga_text_pkg.sv
// Shared types and constants for the VGA text fetch block: FSM state
// encoding, the blank character code, and the hex seven-segment table.
package vga_text_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] SPACE_CHAR = 8'h20;

  // Active-low {g,f,e,d,c,b,a} patterns; element n is the glyph for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/vga_text_fetch_7seg.sv
// hex_to_7seg: combinational 4-bit hex digit to active-low seven-segment decoder.
module hex_to_7seg
  import vga_text_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  // Straight table lookup; every nibble value has a glyph.
  always_comb begin
    segments = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/vga_text_fetch.sv
// vga_text_fetch: on a rising edge of show_req, reads NCHARS/4 words from the
// data memory VGA port starting at BASE_ADDR and unpacks them little-endian into
// a character line buffer read combinationally by the pixel generator.
// Optional macro VGA_TEXT_SHADOW_EN: captures go to a shadow buffer that is
// copied to the display buffer in the DONE cycle, so the VGA side never sees a
// partially refreshed line.
//
// Memory protocol: mem_rd is a one-cycle request with no ready/backpressure;
// the memory presents mem_rdata exactly READ_LAT cycles after mem_rd, and the
// word is sampled on the last WAIT cycle. mem_addr is only meaningful while
// mem_rd is high and otherwise holds the last fetched address.
module vga_text_fetch
  import vga_text_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter int          NCHARS    = 16,
  parameter int          READ_LAT  = 1
)(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      show_req,
  output logic                      mem_rd,
  output logic [31:0]               mem_addr,
  input  logic [31:0]               mem_rdata,
  input  logic [$clog2(NCHARS)-1:0] char_rd_idx,
  output logic [7:0]                char_rd_code,
  output logic                      busy,
  output logic                      done,
  output logic [6:0]                segments,
  output logic [1:0]                state_dbg
);

  localparam int NWORDS = NCHARS / 4;
  localparam int KW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [KW-1:0] K_LAST   = KW'(NWORDS - 1);
  localparam logic [2:0]    LAT_LAST = 3'(READ_LAT - 1);

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [2:0]    lat_q, lat_d;
  logic          pending_q, pending_d;
  logic          show_prev;
  logic          edge_det;
  logic          capture;
  logic [31:0]   fetch_addr;
  logic [31:0]   addr_q;
  logic [7:0]    disp [NCHARS];

  assign edge_det   = show_req & ~show_prev;
  assign fetch_addr = BASE_ADDR + (32'(k_q) << 2);
  assign busy       = (state_q != IDLE);
  assign state_dbg  = state_q;
  assign mem_addr   = (state_q == FETCH) ? fetch_addr : addr_q;

  // FSM and bookkeeping registers, plus the show_req edge-detect history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      lat_q     <= '0;
      pending_q <= 1'b0;
      show_prev <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      lat_q     <= lat_d;
      pending_q <= pending_d;
      show_prev <= show_req;
    end
  end

  // Next-state logic; an edge seen while busy is remembered one-deep, and a
  // remembered (or coincident) request restarts straight out of DONE.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    lat_d     = lat_q;
    pending_d = pending_q | (edge_det & (state_q != IDLE));
    capture   = 1'b0;
    done      = 1'b0;
    mem_rd    = 1'b0;
    case (state_q)
      IDLE: begin
        if (edge_det || pending_q) begin
          state_d   = FETCH;
          k_d       = '0;
          pending_d = 1'b0;
        end
      end
      FETCH: begin
        mem_rd  = 1'b1;
        lat_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == LAT_LAST) begin
          capture = 1'b1;
          if (k_q == K_LAST) begin
            state_d = DONE;
          end else begin
            k_d     = k_q + KW'(1);
            state_d = FETCH;
          end
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      DONE: begin
        done = 1'b1;
        if (pending_q || edge_det) begin
          state_d   = FETCH;
          k_d       = '0;
          pending_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold the last issued address so mem_addr is stable between fetches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= BASE_ADDR;
    end else if (state_q == FETCH) begin
      addr_q <= fetch_addr;
    end
  end

`ifdef VGA_TEXT_SHADOW_EN
  logic [7:0] shadow [NCHARS];

  // Captured bytes land in the shadow line first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCHARS; i++) shadow[i] <= SPACE_CHAR;
    end else if (capture) begin
      for (int i = 0; i < NCHARS; i++)
        if (i / 4 == int'(k_q)) shadow[i] <= mem_rdata[8*(i%4) +: 8];
    end
  end

  // The whole line becomes visible at once when DONE ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCHARS; i++) disp[i] <= SPACE_CHAR;
    end else if (state_q == DONE) begin
      for (int i = 0; i < NCHARS; i++) disp[i] <= shadow[i];
    end
  end
`else
  // Each captured word goes straight into the displayed line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCHARS; i++) disp[i] <= SPACE_CHAR;
    end else if (capture) begin
      for (int i = 0; i < NCHARS; i++)
        if (i / 4 == int'(k_q)) disp[i] <= mem_rdata[8*(i%4) +: 8];
    end
  end
`endif

  assign char_rd_code = disp[char_rd_idx];

  hex_to_7seg u_seg (
    .nibble   (disp[0][3:0]),
    .segments (segments)
  );

endmodule
